// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared sorter types, defaults and index helpers
// Used by sorted_stream_tx and the merge network.
package sorter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_N     = 128;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // LSB of element k in a flat vector of w-bit elements.
  function automatic int elem_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sorted_stream_tx.sv
// rtl/sorted_stream_tx.sv - captures a sorted vector and streams it one element per beat
// Optional macro SORTED_TX_DESCEND_EN streams N-1 down to 0 and checks non-increasing order.
module sorted_stream_tx
  import sorter_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N     = DEF_N,
  localparam int IDX_W = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 order_err
);

  localparam int LSB_W = $clog2(N * WIDTH);

`ifdef SORTED_TX_DESCEND_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
`endif

  state_e               state_q, state_d;
  logic [N*WIDTH-1:0]   cap_q, cap_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [IDX_W-1:0]     out_idx_q, out_idx_d;
  logic                 out_last_q, out_last_d;
  logic                 order_err_q, order_err_d;

  logic [IDX_W-1:0]     nxt_idx;
  logic [LSB_W-1:0]     nxt_lsb;
  logic [WIDTH-1:0]     nxt_data;
  logic                 nxt_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SEND;
      SEND:    if (out_ready && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next element is fetched ahead so every output stays a plain flop.
  always_comb begin
`ifdef SORTED_TX_DESCEND_EN
    nxt_idx  = out_idx_q - 1'b1;
`else
    nxt_idx  = out_idx_q + 1'b1;
`endif
    nxt_lsb  = LSB_W'(elem_lsb(int'(nxt_idx), WIDTH));
    nxt_data = cap_q[nxt_lsb +: WIDTH];
`ifdef SORTED_TX_DESCEND_EN
    nxt_bad  = nxt_data > out_data_q;
`else
    nxt_bad  = nxt_data < out_data_q;
`endif
  end

  always_comb begin
    cap_d       = cap_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    order_err_d = order_err_q;
    if (state_q == IDLE && in_valid) begin
      cap_d       = in_vec;
      out_data_d  = in_vec[elem_lsb(int'(FIRST_IDX), WIDTH) +: WIDTH];
      out_idx_d   = FIRST_IDX;
      out_last_d  = 1'b0;
      order_err_d = 1'b0;
    end else if (state_q == SEND && out_ready && !out_last_q) begin
      out_data_d  = nxt_data;
      out_idx_d   = nxt_idx;
      out_last_d  = (nxt_idx == LAST_IDX);
      order_err_d = order_err_q | nxt_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      order_err_q <= order_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign order_err = order_err_q;

endmodule

// File: tb/tb_sorted_stream_tx.sv
// tb/tb_sorted_stream_tx.sv - self-checking bench for sorted_stream_tx (N=8, WIDTH=3)
// Honours SORTED_TX_DESCEND_EN when the design is built with it.
module tb_sorted_stream_tx;

  localparam int W  = 3;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          order_err;

  int checks = 0;
  int errors = 0;

  sorted_stream_tx #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source index of the b-th emitted beat.
  function automatic int src_idx(input int b);
`ifdef SORTED_TX_DESCEND_EN
    return N - 1 - b;
`else
    return b;
`endif
  endfunction

  function automatic logic [W-1:0] elem(input logic [VW-1:0] v, input int k);
    return W'(v >> (k * W));
  endfunction

  // Reference: emitted stream must be monotonic; error is sticky over beats 1..b.
  task automatic check_beat(input logic [VW-1:0] v, input int b);
    logic       err;
    logic [W-1:0] cur, prv;
    err = 1'b0;
    for (int j = 1; j <= b; j++) begin
      cur = elem(v, src_idx(j));
      prv = elem(v, src_idx(j - 1));
`ifdef SORTED_TX_DESCEND_EN
      if (cur > prv) err = 1'b1;
`else
      if (cur < prv) err = 1'b1;
`endif
    end
    chk("beat_out_valid", 32'(out_valid), 32'd1);
    chk("beat_in_ready",  32'(in_ready),  32'd0);
    chk("beat_out_idx",   32'(out_idx),   32'(src_idx(b)));
    chk("beat_out_data",  32'(out_data),  32'(elem(v, src_idx(b))));
    chk("beat_out_last",  32'(out_last),  32'(b == N - 1));
    chk("beat_order_err", 32'(order_err), 32'(err));
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready.
  task automatic send_frame(input logic [VW-1:0] v, input int mode);
    int   b, cyc;
    logic rdy;
    chk("idle_in_ready",  32'(in_ready),  32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
    b   = 0;
    cyc = 0;
    while (b < N && cyc < 400) begin
      in_vec = VW'($urandom);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(1));
      endcase
      out_ready = rdy;
      check_beat(v, b);
      tick();
      if (rdy) b++;
      cyc++;
    end
    chk("frame_beats", 32'(b), 32'(N));
    out_ready = 1'b0;
    chk("bubble_out_valid", 32'(out_valid), 32'd0);
    chk("bubble_in_ready",  32'(in_ready),  32'd1);
  endtask

  function automatic logic [VW-1:0] rand_vec(input bit sorted);
    int a[N];
    int t;
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) a[k] = int'($urandom_range(7));
    if (sorted) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N - 1 - i; j++)
          if (a[j] > a[j + 1]) begin
            t = a[j]; a[j] = a[j + 1]; a[j + 1] = t;
          end
    end
    v = '0;
    for (int k = 0; k < N; k++) v = v | (VW'(a[k]) << (k * W));
    return v;
  endfunction

  initial begin
    logic [VW-1:0] ramp, rev, bad, v;

    ramp = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    rev  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    bad  = {3'd7, 3'd6, 3'd5, 3'd2, 3'd3, 3'd1, 3'd1, 3'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_idx",   32'(out_idx),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_order_err", 32'(order_err), 32'd0);

    send_frame(ramp, 0);
    send_frame(ramp, 1);
    send_frame(bad, 0);
    send_frame(ramp, 0);
    send_frame(rev, 2);

    // Reset while beat 3 is presented aborts the frame.
    in_valid = 1'b1;
    in_vec   = ramp;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("mid_out_idx", 32'(out_idx), 32'(src_idx(3)));
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_order_err", 32'(order_err), 32'd0);
    chk("abort_out_idx",   32'(out_idx),   32'd0);
    send_frame(ramp, 0);

    // in_valid held high: capture only in the idle slot, noise on in_vec during SEND.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      v = rand_vec(f != 1);
      chk("cont_in_ready",  32'(in_ready),  32'd1);
      chk("cont_out_valid", 32'(out_valid), 32'd0);
      in_vec = v;
      tick();
      for (int b = 0; b < N; b++) begin
        in_vec = VW'($urandom);
        check_beat(v, b);
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("cont_end_in_ready", 32'(in_ready), 32'd1);

    for (int r = 0; r < 6; r++) send_frame(rand_vec(r[0]), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
